// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM states and access-size codes for the unified memory port
package mem_port_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef enum logic [2:0] {IDLE, BUS_IF, BUS_D, RESP_IF, RESP_D} state_t;
    typedef enum logic [2:0] {MODE_WORD = 3'b000, MODE_HALF = 3'b001, MODE_BYTE = 3'b010} size_mode_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response channel used for the fetch, data and memory-bus sides
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              req;
    logic              write;
    logic [2:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    modport master(output req, write, mode, addr, wdata, input ack, rdata);
    modport slave(input req, write, mode, addr, wdata, output ack, rdata);
    // read-only requester view: fetch never writes and always moves whole words
    modport rd_slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// bus_watchdog: counts unacknowledged bus cycles; expired marks the cycle that reaches TIMEOUT
module bus_watchdog #(parameter int TIMEOUT = 255) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    assign expired = enable && cnt == W'(TIMEOUT - 1);
    always_ff @(negedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with a fetch starvation cap
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = mem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W       = mem_port_arbiter_pkg::DATA_W,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_port_arbiter_if.rd_slave     if_port,
    mem_port_arbiter_if.slave        d_port,
    mem_port_arbiter_if.master       bus,
    output logic                     bus_err
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    state_t state;
    logic [SW-1:0] streak;
    logic in_bus, grant_if, grant_d, expired;
    assign in_bus   = state == BUS_IF || state == BUS_D;
    assign grant_if = state == IDLE && if_port.req && (!d_port.req || streak == SW'(MAX_D_STREAK));
    assign grant_d  = state == IDLE && d_port.req && !grant_if;
    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(clk), .reset(reset), .clear(grant_if || grant_d),
        .enable(in_bus && !bus.ack), .expired(expired)
    );
    always_ff @(negedge clk or negedge reset)
        if (!reset) begin
            state         <= IDLE;
            streak        <= '0;
            bus.req       <= 1'b0;
            bus.write     <= 1'b0;
            bus.mode      <= '0;
            bus.addr      <= '0;
            bus.wdata     <= '0;
            if_port.ack   <= 1'b0;
            if_port.rdata <= '0;
            d_port.ack    <= 1'b0;
            d_port.rdata  <= '0;
            bus_err       <= 1'b0;
        end else begin
            if_port.ack <= 1'b0;
            d_port.ack  <= 1'b0;
            case (state)
                IDLE:
                    if (grant_if) begin
                        state     <= BUS_IF;
                        streak    <= '0;
                        bus.req   <= 1'b1;
                        bus.write <= 1'b0;
                        bus.mode  <= MODE_WORD;
                        bus.addr  <= if_port.addr;
                        bus.wdata <= '0;
                    end else if (grant_d) begin
                        state     <= BUS_D;
                        streak    <= !if_port.req ? '0 : streak == SW'(MAX_D_STREAK) ? streak : streak + 1'b1;
                        bus.req   <= 1'b1;
                        bus.write <= d_port.write;
                        bus.mode  <= d_port.mode;
                        bus.addr  <= d_port.addr;
                        bus.wdata <= d_port.wdata;
                    end
                BUS_IF, BUS_D:
                    // an ack on the expiring cycle still wins over the abort
                    if (bus.ack || expired) begin
                        bus.req <= 1'b0;
                        bus_err <= bus_err | !bus.ack;
                        if (state == BUS_IF) begin
                            if_port.ack   <= 1'b1;
                            if_port.rdata <= bus.ack ? bus.rdata : '0;
                            state         <= RESP_IF;
                        end else begin
                            d_port.ack    <= 1'b1;
                            d_port.rdata  <= bus.ack ? bus.rdata : '0;
                            state         <= RESP_D;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for streak, delayed ack, timeout and reset
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic bus_err;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mem_port_arbiter_if ifp ();
    mem_port_arbiter_if dp ();
    mem_port_arbiter_if bus ();
    mem_port_arbiter dut (.clk(clk), .reset(reset), .if_port(ifp), .d_port(dp), .bus(bus), .bus_err(bus_err));

    logic [134:0] obs;
    assign obs = {bus.req, bus.write, bus.mode, bus.addr, bus.wdata, ifp.ack, ifp.rdata, dp.ack, dp.rdata};

    typedef struct {
        logic         if_req;
        logic [31:0]  if_addr;
        logic         d_req;
        logic         d_write;
        logic [2:0]   d_mode;
        logic [31:0]  d_addr;
        logic [31:0]  d_wdata;
        logic         ack;
        logic [31:0]  rdata;
        logic [134:0] exp;
    } vec_t;
    vec_t v[13];

    function automatic logic [134:0] ex(logic br, logic bw, logic [2:0] bm, logic [31:0] ba, logic [31:0] bd,
                                        logic ir, logic [31:0] ird, logic dr, logic [31:0] drd);
        return {br, bw, bm, ba, bd, ir, ird, dr, drd};
    endfunction

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dq, logic dw, logic [2:0] dm, logic [31:0] da,
                                logic [31:0] dd, logic ak, logic [31:0] rd, logic [134:0] e);
        vec_t t;
        t.if_req = ir; t.if_addr = ia; t.d_req = dq; t.d_write = dw; t.d_mode = dm;
        t.d_addr = da; t.d_wdata = dd; t.ack = ak; t.rdata = rd; t.exp = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
    endtask

    logic [31:0] ga[8];
    logic [31:0] ge[6];
    int n;

    initial begin
        v[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0,            ex(1, 0, 0, 32'h40, 0, 0, 0, 0, 0));
        v[1]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h1234ABCD, ex(0, 0, 0, 32'h40, 0, 1, 32'h1234ABCD, 0, 0));
        v[2]  = mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 0,            ex(0, 0, 0, 32'h40, 0, 0, 32'h1234ABCD, 0, 0));
        v[3]  = mk(1, 32'h44, 1, 1, 0, 32'h8, 32'hDEADBEEF, 0, 0, ex(1, 1, 0, 32'h8, 32'hDEADBEEF, 0, 32'h1234ABCD, 0, 0));
        v[4]  = mk(1, 32'h44, 1, 1, 0, 32'h8, 32'hDEADBEEF, 1, 0, ex(0, 1, 0, 32'h8, 32'hDEADBEEF, 0, 32'h1234ABCD, 1, 0));
        v[5]  = mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0,            ex(0, 1, 0, 32'h8, 32'hDEADBEEF, 0, 32'h1234ABCD, 0, 0));
        v[6]  = mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0,            ex(1, 0, 0, 32'h44, 0, 0, 32'h1234ABCD, 0, 0));
        v[7]  = mk(1, 32'h44, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, ex(0, 0, 0, 32'h44, 0, 1, 32'hCAFEF00D, 0, 0));
        v[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 ex(0, 0, 0, 32'h44, 0, 0, 32'hCAFEF00D, 0, 0));
        v[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,      ex(0, 0, 0, 32'h44, 0, 0, 32'hCAFEF00D, 0, 0));
        v[10] = mk(0, 0, 1, 0, 3'b010, 32'h100, 32'h11111111, 0, 0,
                   ex(1, 0, 3'b010, 32'h100, 32'h11111111, 0, 32'hCAFEF00D, 0, 0));
        v[11] = mk(0, 0, 1, 0, 3'b010, 32'h100, 32'h11111111, 1, 32'h77,
                   ex(0, 0, 3'b010, 32'h100, 32'h11111111, 0, 32'hCAFEF00D, 1, 32'h77));
        v[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                   ex(0, 0, 3'b010, 32'h100, 32'h11111111, 0, 32'hCAFEF00D, 0, 32'h77));
        ge = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h200};

        reset = 1'b0;
        ifp.req = 0; ifp.addr = 0;
        dp.req = 0; dp.write = 0; dp.mode = 0; dp.addr = 0; dp.wdata = 0;
        bus.ack = 0; bus.rdata = 0;
        @(posedge clk);
        chk("reset_outs", {25'd0, obs}, 0);
        chk("reset_err", {159'd0, bus_err}, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            ifp.req = v[i].if_req; ifp.addr = v[i].if_addr;
            dp.req = v[i].d_req; dp.write = v[i].d_write; dp.mode = v[i].d_mode;
            dp.addr = v[i].d_addr; dp.wdata = v[i].d_wdata;
            bus.ack = v[i].ack; bus.rdata = v[i].rdata;
            cyc();
            chk($sformatf("vec%0d", i), {25'd0, obs}, {25'd0, v[i].exp});
        end

        // both requesters held: four data grants, one fetch, then data again
        ifp.req = 1; ifp.addr = 32'h300;
        dp.req = 1; dp.write = 0; dp.mode = 0; dp.addr = 32'h200; dp.wdata = 0;
        bus.ack = 1; bus.rdata = 0;
        n = 0;
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (bus.req && n < 8) begin
                ga[n] = bus.addr;
                n++;
            end
        end
        chk("streak_count", 160'(n), 160'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("streak_grant%0d", i), {128'd0, ga[i]}, {128'd0, ge[i]});
        ifp.req = 0; dp.req = 0; bus.ack = 0;
        cyc();

        // ack delayed seven cycles: bus outputs frozen, ready one edge after ack
        dp.req = 1; dp.write = 1; dp.mode = 3'b001; dp.addr = 32'h20; dp.wdata = 32'hA5A5A5A5;
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("hold%0d", i), {25'd0, obs}, {25'd0, ex(1, 1, 3'b001, 32'h20, 32'hA5A5A5A5, 0, 0, 0, 0)});
            if (i < 7) cyc();
        end
        bus.ack = 1; bus.rdata = 32'h99;
        cyc();
        chk("late_ack", {25'd0, obs}, {25'd0, ex(0, 1, 3'b001, 32'h20, 32'hA5A5A5A5, 0, 0, 1, 32'h99)});
        dp.req = 0; bus.ack = 0;
        cyc();
        chk("late_ack_idle", {158'd0, dp.ack, bus.req}, 0);

        // no ack at all: abort on the 255th waiting cycle
        dp.req = 1; dp.write = 0; dp.mode = 0; dp.addr = 32'h30;
        cyc();
        for (int i = 0; i < 254; i++) cyc();
        chk("wd_pre", {157'd0, bus.req, dp.ack, bus_err}, {157'd0, 3'b100});
        cyc();
        chk("wd_abort", {25'd0, obs}, {25'd0, ex(0, 0, 0, 32'h30, 32'hA5A5A5A5, 0, 0, 1, 0)});
        chk("wd_err", {159'd0, bus_err}, 1);
        dp.req = 0;
        cyc();
        chk("wd_sticky", {158'd0, bus_err, dp.ack}, {158'd0, 2'b10});

        // reset mid-access drops everything at once, then fetch alone is served
        dp.req = 1; dp.write = 1; dp.addr = 32'h40;
        cyc();
        chk("pre_reset_req", {159'd0, bus.req}, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_outs", {25'd0, obs}, 0);
        chk("async_reset_err", {159'd0, bus_err}, 0);
        @(posedge clk);
        reset = 1'b1; dp.req = 0; ifp.req = 1; ifp.addr = 32'h80;
        cyc();
        chk("post_reset_if", {25'd0, obs}, {25'd0, ex(1, 0, 0, 32'h80, 0, 0, 0, 0, 0)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
